gpr_wb_arb: RTL and testbench
=============================

GPR_WB_ARB -- requirements
Module: gpr_wb_arb

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- FIFO_DEPTH, 4, port-B queue entries; power of two, 2 or more.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, reset; synchronous, active-high.
- a_valid, in, 1, single-cycle pipeline result valid.
- a_ready, out, 1, port A accepted this cycle.
- a_addr, in, ADDR_W, port A destination register.
- a_data, in, DATA_W, port A result.
- b_valid, in, 1, long-latency unit result valid.
- b_ready, out, 1, port B queue can accept.
- b_addr, in, ADDR_W, port B destination register.
- b_data, in, DATA_W, port B result.
- iss_valid, in, 1, long-latency operation issued.
- iss_addr, in, ADDR_W, destination of the issued operation.
- we_, out, 1, register-file write enable, active-low.
- w_addr, out, ADDR_W, register-file write address.
- w_data, out, DATA_W, register-file write data.
- pend, out, 2^ADDR_W, per-register pending-write scoreboard.

Function
REQ-003 A port-B beat is accepted when b_valid=1 and b_ready=1 in the same cycle; accepted beats enter the queue in FIFO order.
REQ-004 b_ready = 1 when the queue count < FIFO_DEPTH, combinational from registered count only; no combinational path from b_valid.
REQ-005 Selection each cycle, with FIFO_FULL meaning count == FIFO_DEPTH:
- FIFO_FULL: queue head wins; a_ready=0.
- else a_valid=1: port A wins; a_ready=1.
- else queue non-empty: head wins.
- else idle.
REQ-006 a_ready = 1 whenever the queue is not full, independent of a_valid.
REQ-007 Output latency is one cycle: the winner's addr/data appears registered on w_addr/w_data with we_=0 the next cycle; we_=1 otherwise, and w_addr/w_data then hold their previous values.
REQ-008 The queue pops on the cycle its head wins. Simultaneous push and pop leaves the count unchanged. A beat pushed into an empty queue is not selectable until the following cycle.
REQ-009 Queue pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-010 Scoreboard set: pend[iss_addr] is set on the edge after iss_valid=1.
REQ-011 Scoreboard clear: pend[x] is cleared on the edge on which a queue-head write to x is registered into the output; port-A writes never clear pend.
REQ-012 If set and clear target the same register in the same cycle, set wins.
REQ-013 pend is a registered output.

Reset
REQ-014 While reset=1 on a rising edge: queue count, pointers and pend are cleared; we_=1; w_addr=0; w_data=0.
REQ-015 Queue contents are lost on reset, including reset asserted mid-operation.
REQ-016 During the reset cycle b_ready and a_ready evaluate from the cleared state on the next cycle; inputs sampled in the reset cycle are discarded.

Configuration
REQ-017 Macro GPR_WB_ZERO_DISCARD_EN.
- Defined: any selected write with address 0 still consumes its slot (a_ready/pop as normal) but produces we_=1 and never sets or clears pend[0]; iss_valid with iss_addr=0 is ignored.
- Undefined: address 0 is treated like every other register.

Verification
REQ-018 Idle then a_valid=1, a_addr=3, a_data=0x11 -> next cycle we_=0, w_addr=3, w_data=0x11; the following cycle we_=1.
REQ-019 iss_valid (addr 7), then b beat (addr 7, data 0xAB) with port A idle -> pend[7]=1 until the cycle w_addr=7, w_data=0xAB is output, then 0.
REQ-020 Port A valid every cycle, push 4 B beats -> b_ready=0 after the fourth push; next cycle a_ready=0 and the B head is written; B order is preserved.
REQ-021 Simultaneous iss_valid and head completion to register 9 -> pend[9] remains 1.
REQ-022 Reset asserted with 3 queued beats -> next cycle count 0, pend all zero, we_=1, b_ready=1.
REQ-023 With GPR_WB_ZERO_DISCARD_EN defined, a_valid with a_addr=0 -> a_ready=1, we_ stays 1.

Source files
------------

// File: rtl/gpr_wb_arb.sv
// GPR write-back arbiter: single-cycle port A vs. queued long-latency port B, with a pending-write scoreboard.
// Optional GPR_WB_ZERO_DISCARD_EN: writes and issues to register 0 are dropped.
module gpr_wb_arb #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     we_,
    output logic [ADDR_W-1:0]        w_addr,
    output logic [DATA_W-1:0]        w_data,
    output logic [(1<<ADDR_W)-1:0]   pend
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              full, empty, push, pop, sel_a, sel_any, discard, iss_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   set_mask, clr_mask;

    // Readiness depends only on the registered count, never on b_valid.
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign b_ready = !full;
    assign a_ready = !full;

    assign push    = b_valid && !full;
    assign sel_a   = a_valid && !full;
    assign pop     = !sel_a && !empty;
    assign sel_any = sel_a || pop;

    always_comb begin
        sel_addr = q_addr[rd_ptr];
        sel_data = q_data[rd_ptr];
        if (sel_a) begin
            sel_addr = a_addr;
            sel_data = a_data;
        end
    end

`ifdef GPR_WB_ZERO_DISCARD_EN
    assign discard = (sel_addr == '0);
    assign iss_ok  = iss_valid && (iss_addr != '0);
`else
    assign discard = 1'b0;
    assign iss_ok  = iss_valid;
`endif

    // Set is OR'd in after the clear so a same-cycle set wins.
    assign set_mask = iss_ok ? (NREG'(1) << iss_addr) : '0;
    assign clr_mask = (pop && !discard) ? (NREG'(1) << sel_addr) : '0;

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            q_addr[wr_ptr] <= b_addr;
            q_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pend   <= '0;
            we_    <= 1'b1;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pend <= (pend & ~clr_mask) | set_mask;
            we_  <= !(sel_any && !discard);
            if (sel_any && !discard) begin
                w_addr <= sel_addr;
                w_data <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_gpr_wb_arb.sv
// Directed bench for gpr_wb_arb: expected writes go into a scoreboard queue, a negedge monitor checks them.
module tb_gpr_wb_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, iss_valid;
    logic        a_ready, b_ready, we_;
    logic [4:0]  a_addr, b_addr, iss_addr, w_addr;
    logic [31:0] a_data, b_data, w_data;
    logic [31:0] pend;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    gpr_wb_arb #(.ADDR_W(5), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .we_(we_), .w_addr(w_addr), .w_data(w_data), .pend(pend)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every write-enable cycle must match the next expected write.
    always @(negedge clk) begin
        if (we_ === 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, none expected", w_addr, w_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (w_addr !== e.a || w_data !== e.d) begin
                    n_bad++;
                    $display("FAIL write_order: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             w_addr, w_data, e.a, e.d);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        iss_valid = 0; iss_addr = 0;
        repeat (2) tick();
        check("rst_we", we_, 1);
        check("rst_waddr", w_addr, 0);
        check("rst_wdata", w_data, 0);
        check("rst_pend", pend, 0);
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);
        reset = 1'b0;

        // Port A single write, one-cycle latency.
        expect_wr(5'd3, 32'h11);
        a_valid = 1; a_addr = 3; a_data = 32'h11;
        check("t1_a_ready", a_ready, 1);
        tick();
        a_valid = 0;
        check("t1_we", we_, 0);
        check("t1_waddr", w_addr, 3);
        check("t1_wdata", w_data, 32'h11);
        tick();
        check("t1_we_idle", we_, 1);
        check("t1_waddr_hold", w_addr, 3);

        // Issue then B completion to register 7.
        iss_valid = 1; iss_addr = 7;
        tick();
        iss_valid = 0;
        check("t2_pend_set", pend[7], 1);
        expect_wr(5'd7, 32'hAB);
        b_valid = 1; b_addr = 7; b_data = 32'hAB;
        check("t2_b_ready", b_ready, 1);
        tick();
        b_valid = 0;
        check("t2_pend_hold", pend[7], 1);
        check("t2_not_yet", we_, 1);
        tick();
        check("t2_we", we_, 0);
        check("t2_waddr", w_addr, 7);
        check("t2_wdata", w_data, 32'hAB);
        check("t2_pend_clr", pend[7], 0);
        tick();
        check("t2_we_idle", we_, 1);

        // Fill the queue under constant port-A traffic; pointers wrap here.
        for (int i = 0; i < 4; i++) expect_wr(5'(1 + i), 32'hA0 + i);
        expect_wr(5'd20, 32'hB0);
        expect_wr(5'd5, 32'hA5);
        for (int i = 1; i < 4; i++) expect_wr(5'(20 + i), 32'hB0 + i);
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_addr = 5'(1 + i); a_data = 32'hA0 + i;
            b_valid = 1; b_addr = 5'(20 + i); b_data = 32'hB0 + i;
            check("t3_a_ready_fill", a_ready, 1);
            tick();
        end
        b_valid = 0;
        check("t3_b_ready_full", b_ready, 0);
        check("t3_a_ready_full", a_ready, 0);
        a_addr = 5; a_data = 32'hA5;
        tick();
        check("t3_head_we", we_, 0);
        check("t3_head_addr", w_addr, 20);
        check("t3_a_ready_after", a_ready, 1);
        tick();
        a_valid = 0;
        repeat (3) tick();
        tick();
        check("t3_drained_we", we_, 1);
        check("t3_drained_b_ready", b_ready, 1);

        // Same-cycle set and clear of register 9: set wins.
        iss_valid = 1; iss_addr = 9;
        tick();
        iss_valid = 0;
        check("t4_pend_set", pend[9], 1);
        expect_wr(5'd9, 32'h99);
        b_valid = 1; b_addr = 9; b_data = 32'h99;
        tick();
        b_valid = 0;
        iss_valid = 1; iss_addr = 9;
        tick();
        iss_valid = 0;
        check("t4_we", we_, 0);
        check("t4_waddr", w_addr, 9);
        check("t4_pend_set_wins", pend[9], 1);
        // Port-A write to a pending register leaves it pending.
        expect_wr(5'd9, 32'h55);
        a_valid = 1; a_addr = 9; a_data = 32'h55;
        tick();
        a_valid = 0;
        check("t4_a_we", we_, 0);
        check("t4_a_no_clear", pend[9], 1);
        expect_wr(5'd9, 32'h77);
        b_valid = 1; b_addr = 9; b_data = 32'h77;
        tick();
        b_valid = 0;
        tick();
        check("t4_b_clear", pend, 0);

        // Register 0 handling.
`ifndef GPR_WB_ZERO_DISCARD_EN
        expect_wr(5'd0, 32'h5A);
`endif
        a_valid = 1; a_addr = 0; a_data = 32'h5A;
        check("t5_zero_a_ready", a_ready, 1);
        tick();
        a_valid = 0;
        iss_valid = 1; iss_addr = 0;
`ifdef GPR_WB_ZERO_DISCARD_EN
        check("t5_zero_we", we_, 1);
`else
        check("t5_zero_we", we_, 0);
`endif
        tick();
        iss_valid = 0;
`ifdef GPR_WB_ZERO_DISCARD_EN
        check("t5_zero_pend", pend[0], 0);
`else
        check("t5_zero_pend", pend[0], 1);
`endif

        // Reset with three queued beats; reset-cycle inputs are discarded.
        for (int i = 0; i < 3; i++) begin
            expect_wr(5'(10 + i), 32'hC0 + i);
            a_valid = 1; a_addr = 5'(10 + i); a_data = 32'hC0 + i;
            b_valid = 1; b_addr = 5'(24 + i); b_data = 32'hD0 + i;
            iss_valid = 1; iss_addr = 5'(24 + i);
            tick();
        end
        reset = 1;
        a_addr = 13; b_addr = 27; iss_addr = 27;
        tick();
        check("t6_we", we_, 1);
        check("t6_waddr", w_addr, 0);
        check("t6_wdata", w_data, 0);
        check("t6_pend", pend, 0);
        check("t6_b_ready", b_ready, 1);
        check("t6_a_ready", a_ready, 1);
        reset = 0;
        a_valid = 0; b_valid = 0; iss_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_queue_lost", we_, 1);
        end
        check("t6_pend_idle", pend, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
